clk_div_multi: RTL and testbench

- Multi-channel programmable clock/tick generator; the successor of the fixed single-divisor divider.
- Each of CHANNELS independent channels has a runtime-loadable period, duty (high count) and mode (continuous or one-shot).
- Reconfiguration while running is glitch-free: new values apply only at a period boundary.
- Feeds enables, baud ticks and blink/scan strobes in the synthesis top level.

---
 rtl/clk_div_pkg.sv | 36 +++
 rtl/clk_div_chan.sv | 118 +++++++++++
 rtl/clk_div_multi.sv | 53 +++++
 tb/tb_clk_div_multi.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel state, mode encoding and write-time clamping rules.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Clamp helpers work on a wide value; callers size in and out.
    localparam int unsigned CLAMP_W = 64;

    // Width of a channel index, never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A period shorter than two cycles cannot toggle; force 2.
    function automatic logic [CLAMP_W-1:0] clamp_div(
        input logic [CLAMP_W-1:0] d
    );
        return (d < CLAMP_W'(2)) ? CLAMP_W'(2) : d;
    endfunction

    // High time longer than the period means 100% duty.
    function automatic logic [CLAMP_W-1:0] clamp_high(
        input logic [CLAMP_W-1:0] h,
        input logic [CLAMP_W-1:0] d
    );
        return (h > d) ? d : h;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active config and IDLE/RUN FSM.
// New config takes effect only at a period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter longint unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             cfg_mode,
    input  logic             en,
    input  logic             start,
    output logic             out,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_DIV / 2);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic             mode_act;
    logic [WIDTH-1:0] div_shd;
    logic [WIDTH-1:0] high_shd;
    logic             mode_shd;
    logic             pend;

    logic [WIDTH-1:0] div_new;
    logic [WIDTH-1:0] high_new;
    logic             run;
    logic             last;
    logic             boundary;
    logic             go;

    // Clamp the incoming write so stored values are always legal.
    always_comb begin
        div_new  = WIDTH'(clamp_div(CLAMP_W'(cfg_div)));
        high_new = WIDTH'(clamp_high(CLAMP_W'(cfg_high),
                                     CLAMP_W'(div_new)));
    end

    assign run  = (state == RUN);
    assign last = (cnt == div_act - WIDTH'(1));
    assign go   = (mode_act == MODE_CONT) || start;

    // Active config may change when idle, at a wrap, or on abort.
    assign boundary = !run || !en || last;

    assign out  = run && (cnt < high_act);
    assign tick = run && last;
    assign busy = run;

    // Channel FSM, counter and shadow/active config registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_act  <= DIV_RST;
            high_act <= HIGH_RST;
            mode_act <= MODE_CONT;
            div_shd  <= DIV_RST;
            high_shd <= HIGH_RST;
            mode_shd <= MODE_CONT;
            pend     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && go) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (last) begin
                        cnt <= '0;
                        if (mode_act == MODE_ONESHOT) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            endcase

            if (cfg_we) begin
                div_shd  <= div_new;
                high_shd <= high_new;
                mode_shd <= cfg_mode;
            end

            if (boundary) begin
                pend <= 1'b0;
                if (cfg_we) begin
                    div_act  <= div_new;
                    high_act <= high_new;
                    mode_act <= cfg_mode;
                end else if (pend) begin
                    div_act  <= div_shd;
                    high_act <= high_shd;
                    mode_act <= mode_shd;
                end
            end else if (cfg_we) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator.
// Routes config writes to one channel and replicates the channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned     CHANNELS    = 4,
    parameter int unsigned     WIDTH       = 32,
    parameter longint unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [ch_w(CHANNELS)-1:0]    cfg_ch,
    input  logic [WIDTH-1:0]             cfg_div,
    input  logic [WIDTH-1:0]             cfg_high,
    input  logic                         cfg_mode,
    input  logic [CHANNELS-1:0]          ch_en,
    input  logic [CHANNELS-1:0]          start,
    output logic [CHANNELS-1:0]          out,
    output logic [CHANNELS-1:0]          tick,
    output logic [CHANNELS-1:0]          busy
);

    logic [CHANNELS-1:0] we;

    // Decode the channel index; out-of-range indices hit nothing.
    always_comb begin
        we = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            we[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_we   (we[g]),
            .cfg_div  (cfg_div),
            .cfg_high (cfg_high),
            .cfg_mode (cfg_mode),
            .en       (ch_en[g]),
            .start    (start[g]),
            .out      (out[g]),
            .tick     (tick[g]),
            .busy     (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi.
// Directed scenarios plus random traffic against a period-level model.
module tb_clk_div_multi;

    localparam int CHN = 5;
    localparam int W   = 16;
    localparam int DEF = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_we = 1'b0;
    logic [2:0]     cfg_ch = '0;
    logic [W-1:0]   cfg_div = '0;
    logic [W-1:0]   cfg_high = '0;
    logic           cfg_mode = 1'b0;
    logic [CHN-1:0] ch_en = '0;
    logic [CHN-1:0] start = '0;
    logic [CHN-1:0] out;
    logic [CHN-1:0] tick;
    logic [CHN-1:0] busy;

    always #5 clk = ~clk;

    clk_div_multi #(
        .CHANNELS    (CHN),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_mode (cfg_mode),
        .ch_en    (ch_en),
        .start    (start),
        .out      (out),
        .tick     (tick),
        .busy     (busy)
    );

    // Period-level view of a channel: where we are in the period,
    // the settings of this period and the settings queued for later.
    typedef struct {
        bit run;
        int pos;
        int div;
        int high;
        bit oneshot;
        int q_div;
        int q_high;
        bit q_oneshot;
        bit queued;
    } ch_m_t;

    ch_m_t m [CHN];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        foreach (m[i]) begin
            m[i] = '{run: 0, pos: 0, div: DEF, high: DEF / 2,
                     oneshot: 0, q_div: DEF, q_high: DEF / 2,
                     q_oneshot: 0, queued: 0};
        end
    endfunction

    // Advance every channel by one clock using the inputs now applied.
    function automatic void m_step();
        for (int c = 0; c < CHN; c++) begin
            ch_m_t s = m[c];
            bit    wr = cfg_we && (int'(cfg_ch) == c);
            int    nd = (cfg_div < 2) ? 2 : int'(cfg_div);
            int    nh = (int'(cfg_high) > nd) ? nd : int'(cfg_high);
            bit    fin = s.run && (s.pos == s.div - 1);
            bit    bnd = !s.run || !ch_en[c] || fin;
            if (!ch_en[c]) begin
                s.run = 0;
                s.pos = 0;
            end else if (!s.run) begin
                if (!s.oneshot || start[c]) begin
                    s.run = 1;
                    s.pos = 0;
                end
            end else if (fin) begin
                s.pos = 0;
                if (s.oneshot) s.run = 0;
            end else begin
                s.pos = s.pos + 1;
            end
            if (wr) begin
                s.q_div = nd;
                s.q_high = nh;
                s.q_oneshot = cfg_mode;
            end
            if (bnd) begin
                if (wr || s.queued) begin
                    s.div = s.q_div;
                    s.high = s.q_high;
                    s.oneshot = s.q_oneshot;
                end
                s.queued = 0;
            end else if (wr) begin
                s.queued = 1;
            end
            m[c] = s;
        end
    endfunction

    task automatic compare();
        logic [CHN-1:0] eo;
        logic [CHN-1:0] et;
        logic [CHN-1:0] eb;
        for (int i = 0; i < CHN; i++) begin
            eo[i] = m[i].run && (m[i].pos < m[i].high);
            et[i] = m[i].run && (m[i].pos == m[i].div - 1);
            eb[i] = m[i].run;
        end
        chk("out", 32'(out), 32'(eo));
        chk("tick", 32'(tick), 32'(et));
        chk("busy", 32'(busy), 32'(eb));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input int ch, input int d, input int h,
                      input bit md);
        cfg_ch = 3'(ch);
        cfg_div = W'(d);
        cfg_high = W'(h);
        cfg_mode = md;
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
    endtask

    int hi;
    int tk;
    int bz;

    initial begin
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Default period on channel 0.
        ch_en[0] = 1'b1;
        cycle();
        hi = 0; tk = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(out[0]);
            tk += int'(tick[0]);
            cycle();
        end
        chk("t1_high", 32'(hi), 10);
        chk("t1_tick", 32'(tk), 2);

        // Reconfigure channel 1 mid-period.
        wr(1, 8, 2, 0);
        ch_en[1] = 1'b1;
        cycle();
        repeat (3) cycle();
        wr(1, 4, 3, 0);
        hi = 0; tk = 0;
        for (int i = 0; i < 12; i++) begin
            hi += int'(out[1]);
            tk += int'(tick[1]);
            cycle();
        end
        chk("t2_high", 32'(hi), 6);
        chk("t2_tick", 32'(tk), 3);

        // Clamped config on channel 2.
        wr(2, 0, 7, 0);
        ch_en[2] = 1'b1;
        cycle();
        hi = 0; tk = 0;
        for (int i = 0; i < 6; i++) begin
            hi += int'(out[2]);
            tk += int'(tick[2]);
            cycle();
        end
        chk("t3_high", 32'(hi), 6);
        chk("t3_tick", 32'(tk), 3);

        // One-shot on channel 3 with an ignored retrigger.
        wr(3, 6, 1, 1);
        ch_en[3] = 1'b1;
        cycle();
        chk("t4_wait", 32'(busy[3]), 0);
        start[3] = 1'b1;
        cycle();
        start[3] = 1'b0;
        hi = 0; tk = 0; bz = 0;
        for (int i = 0; i < 10; i++) begin
            hi += int'(out[3]);
            tk += int'(tick[3]);
            bz += int'(busy[3]);
            start[3] = (i == 2);
            cycle();
            start[3] = 1'b0;
        end
        chk("t4_busy", 32'(bz), 6);
        chk("t4_high", 32'(hi), 1);
        chk("t4_tick", 32'(tk), 1);

        // Abort channel 0 at count 3 and restart.
        for (int i = 0; i < 20 && m[0].pos != 3; i++) cycle();
        ch_en[0] = 1'b0;
        cycle();
        chk("t5_busy", 32'(busy[0]), 0);
        chk("t5_out", 32'(out[0]), 0);
        ch_en[0] = 1'b1;
        cycle();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            hi += int'(out[0]);
            cycle();
        end
        chk("t5_high", 32'(hi), 5);

        // Reset with a queued write, then an out-of-range write.
        wr(0, 4, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_out", 32'(out), 0);
        chk("t6_tick", 32'(tick), 0);
        chk("t6_busy", 32'(busy), 0);
        cycle();
        rst_n = 1'b1;
        wr(5, 3, 1, 0);
        hi = 0; tk = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(out[0]);
            tk += int'(tick[0]);
            cycle();
        end
        chk("t6_high", 32'(hi), 10);
        chk("t6_tick", 32'(tk), 2);

        // Random traffic.
        ch_en = '1;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CHN; c++) begin
                if ($urandom_range(0, 24) == 0) ch_en[c] = ~ch_en[c];
                start[c] = ($urandom_range(0, 7) == 0);
            end
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_div = W'($urandom_range(0, 12));
            cfg_high = W'($urandom_range(0, 14));
            cfg_mode = 1'($urandom_range(0, 1));
            if (i == 1000) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end
        cfg_we = 1'b0;
        start = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
